// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART baud tick controller.
package uart_pkg;

  localparam int DIV_W      = 16;
  localparam int OVERSAMPLE = 16;

  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(27);
  localparam logic [DIV_W-1:0] MIN_DIV     = DIV_W'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/baud_ctrl_if.sv
// Config handshake, engine busy flags and tick outputs of the baud controller.
interface baud_ctrl_if;
  import uart_pkg::*;

  logic             enable;
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic [3:0]       cfg_frac;
  logic             cfg_ready;
  logic             cfg_err;
  logic             tx_busy;
  logic             rx_busy;
  logic             os_tick;
  logic             bit_tick;
  logic [DIV_W-1:0] cur_div;

  modport master (
    output enable, cfg_valid, cfg_div, cfg_frac, tx_busy, rx_busy,
    input  cfg_ready, cfg_err, os_tick, bit_tick, cur_div
  );

  modport slave (
    input  enable, cfg_valid, cfg_div, cfg_frac, tx_busy, rx_busy,
    output cfg_ready, cfg_err, os_tick, bit_tick, cur_div
  );

endinterface

// File: rtl/baud_tick_counter.sv
// Divider / oversample counter chain producing os_tick and bit_tick.
// Fractional divisor support is compiled in with UART_FRAC_DIV_EN.
module baud_tick_counter #(
  parameter int W  = 16,
  parameter int OS = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         cnt_en,
  input  logic [W-1:0] div,
  input  logic [3:0]   frac,
  output logic         os_tick,
  output logic         bit_tick
);
  localparam int OS_W = $clog2(OS);

  logic [W-1:0]    div_cnt_q, div_cnt_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [W-1:0]    last_cnt;

`ifdef UART_FRAC_DIV_EN
  logic [3:0] acc_q, acc_d;
  logic [4:0] acc_sum;

  // A carry out of the phase accumulator stretches the current period by one clk.
  assign acc_sum  = {1'b0, acc_q} + {1'b0, frac};
  assign last_cnt = div - W'(1) + W'(acc_sum[4]);
`else
  logic [3:0] unused_frac;
  assign unused_frac = frac;
  assign last_cnt    = div - W'(1);
`endif

  assign os_tick  = cnt_en && (div_cnt_q == last_cnt);
  assign bit_tick = os_tick && (os_cnt_q == OS_W'(OS - 1));

  always_comb begin
    div_cnt_d = div_cnt_q;
    os_cnt_d  = os_cnt_q;
`ifdef UART_FRAC_DIV_EN
    acc_d     = acc_q;
`endif
    if (clr) begin
      div_cnt_d = '0;
      os_cnt_d  = '0;
`ifdef UART_FRAC_DIV_EN
      acc_d     = '0;
`endif
    end else if (os_tick) begin
      div_cnt_d = '0;
      os_cnt_d  = os_cnt_q + OS_W'(1);
`ifdef UART_FRAC_DIV_EN
      acc_d     = acc_sum[3:0];
`endif
    end else if (cnt_en) begin
      div_cnt_d = div_cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
`ifdef UART_FRAC_DIV_EN
      acc_q     <= '0;
`endif
    end else begin
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
`ifdef UART_FRAC_DIV_EN
      acc_q     <= acc_d;
`endif
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud tick controller: FSM and divisor handshake around baud_tick_counter.
// Fractional divisor (cfg_frac) takes effect only when built with UART_FRAC_DIV_EN.
//
// state | meaning
// IDLE  | enable low, counters held at zero, cfg applied immediately
// RUN   | ticking at cur_div
// PEND  | new divisor held, ticking at old divisor until both engines idle
module baud_ctrl
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  baud_ctrl_if.slave bus
);
  state_e           state_q, state_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d, pend_div_q, pend_div_d;
  logic [3:0]       cur_frac_q, cur_frac_d, pend_frac_q, pend_frac_d;
  logic             err_q, err_d;
  logic             rdy_q;
  logic             active, apply, take, legal, cfg_ready;

  assign cfg_ready = rdy_q && (state_q != PEND);
  assign active    = (state_q != IDLE) && bus.enable;
  assign apply     = (state_q == PEND) && (!bus.enable || (!bus.tx_busy && !bus.rx_busy));
  assign take      = bus.cfg_valid && cfg_ready;
  assign legal     = bus.cfg_div >= MIN_DIV;

  always_comb begin
    state_d     = state_q;
    cur_div_d   = cur_div_q;
    cur_frac_d  = cur_frac_q;
    pend_div_d  = pend_div_q;
    pend_frac_d = pend_frac_q;
    err_d       = take && !legal;
    case (state_q)
      IDLE: begin
        if (take && legal) begin
          cur_div_d  = bus.cfg_div;
          cur_frac_d = bus.cfg_frac;
        end
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          if (take && legal) begin
            cur_div_d  = bus.cfg_div;
            cur_frac_d = bus.cfg_frac;
          end
        end else if (take && legal) begin
          pend_div_d  = bus.cfg_div;
          pend_frac_d = bus.cfg_frac;
          state_d     = PEND;
        end
      end
      PEND: begin
        if (apply) begin
          cur_div_d  = pend_div_q;
          cur_frac_d = pend_frac_q;
          state_d    = bus.enable ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_div_q   <= DEFAULT_DIV;
      cur_frac_q  <= '0;
      pend_div_q  <= '0;
      pend_frac_q <= '0;
      err_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_div_q   <= cur_div_d;
      cur_frac_q  <= cur_frac_d;
      pend_div_q  <= pend_div_d;
      pend_frac_q <= pend_frac_d;
      err_q       <= err_d;
      rdy_q       <= 1'b1;
    end
  end

  // The apply cycle clears the chain, so no tick can fire on it.
  baud_tick_counter #(
    .W  (DIV_W),
    .OS (OVERSAMPLE)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (!active || apply),
    .cnt_en   (active && !apply),
    .div      (cur_div_q),
    .frac     (cur_frac_q),
    .os_tick  (bus.os_tick),
    .bit_tick (bus.bit_tick)
  );

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = err_q;
  assign bus.cur_div   = cur_div_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: directed scenarios plus random traffic
// against a tick-schedule reference model.
module tb_baud_ctrl;
  import uart_pkg::*;

`ifdef UART_FRAC_DIV_EN
  localparam longint FRAC_ON = 1;
`else
  localparam longint FRAC_ON = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  baud_ctrl_if bus ();

  baud_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  longint cyc    = 0;

  // Reference model: mode 0 idle / 1 running / 2 holding a pending divisor.
  // Tick k after a (re)start lands at start + k*div + floor(k*frac/16).
  int     m_mode;
  bit     m_rdy;
  bit     m_err;
  int     m_cur, m_frac, m_pend, m_pfrac;
  longint m_start;
  int     m_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_rdy   = 1'b0;
    m_err   = 1'b0;
    m_cur   = 27;
    m_frac  = 0;
    m_pend  = 0;
    m_pfrac = 0;
    m_start = 0;
    m_k     = 0;
  endtask

  task automatic cycle();
    bit     en, busy, apply, cnt, e_os, e_bit, e_rdy, take, good;
    longint nt;
    @(negedge clk);
    en    = bus.enable;
    busy  = bus.tx_busy || bus.rx_busy;
    e_rdy = m_rdy && (m_mode != 2);
    apply = (m_mode == 2) && (!en || !busy);
    cnt   = (m_mode != 0) && en && !apply;
    nt    = m_start + longint'(m_k + 1) * m_cur + FRAC_ON * ((longint'(m_k + 1) * m_frac) / 16);
    e_os  = cnt && (cyc == nt);
    e_bit = e_os && (((m_k + 1) % OVERSAMPLE) == 0);
    check("os_tick",   32'(bus.os_tick),   32'(e_os));
    check("bit_tick",  32'(bus.bit_tick),  32'(e_bit));
    check("cfg_ready", 32'(bus.cfg_ready), 32'(e_rdy));
    check("cfg_err",   32'(bus.cfg_err),   32'(m_err));
    check("cur_div",   32'(bus.cur_div),   32'(m_cur));
    take  = bus.cfg_valid && e_rdy;
    good  = take && (int'(bus.cfg_div) >= 2);
    m_err = take && !good;
    if (e_os) m_k++;
    case (m_mode)
      0: begin
        if (good) begin m_cur = int'(bus.cfg_div); m_frac = int'(bus.cfg_frac); end
        if (en) begin m_mode = 1; m_start = cyc; m_k = 0; end
      end
      1: begin
        if (!en) begin
          m_mode = 0;
          if (good) begin m_cur = int'(bus.cfg_div); m_frac = int'(bus.cfg_frac); end
        end else if (good) begin
          m_pend = int'(bus.cfg_div); m_pfrac = int'(bus.cfg_frac); m_mode = 2;
        end
      end
      default: begin
        if (apply) begin
          m_cur  = m_pend;
          m_frac = m_pfrac;
          if (en) begin m_mode = 1; m_start = cyc; m_k = 0; end
          else m_mode = 0;
        end
      end
    endcase
    m_rdy = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic offer(input int d, input int f);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = DIV_W'(d);
    bus.cfg_frac  = 4'(f);
    cycle();
    bus.cfg_valid = 1'b0;
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    check("rst_os_tick",   32'(bus.os_tick),   32'd0);
    check("rst_bit_tick",  32'(bus.bit_tick),  32'd0);
    check("rst_cfg_err",   32'(bus.cfg_err),   32'd0);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
    check("rst_cur_div",   32'(bus.cur_div),   32'd27);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b1;
    bus.enable    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_frac  = '0;
    bus.tx_busy   = 1'b0;
    bus.rx_busy   = 1'b0;
    model_reset();
    #1;
    do_reset();
    run(2);

    // Default divisor: ticks every 27, bit tick every 432.
    bus.enable = 1'b1;
    run(450);

    // Divisor change held off while the transmitter is busy.
    bus.tx_busy = 1'b1;
    offer(54, 0);
    run(100);
    bus.tx_busy = 1'b0;
    run(120);

    // Illegal divisor rejected with an error pulse.
    offer(1, 0);
    run(10);
    offer(0, 0);
    run(60);

    // enable dropped while pending: divisor applied on the way to idle.
    bus.tx_busy = 1'b1;
    offer(100, 0);
    run(30);
    bus.enable = 1'b0;
    run(5);
    bus.enable = 1'b1;
    run(110);

    // Reset mid-frame with a pending divisor.
    offer(54, 0);
    run(750);
    do_reset();
    bus.tx_busy = 1'b0;
    run(3);
    bus.enable = 1'b1;
    run(60);

    // Fractional divisor 27 + 8/16 (ignored in the default build).
    bus.enable = 1'b0;
    run(2);
    offer(27, 8);
    bus.enable = 1'b1;
    run(460);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      if ($urandom_range(0, 29) == 0) bus.tx_busy = ~bus.tx_busy;
      if ($urandom_range(0, 29) == 0) bus.rx_busy = ~bus.rx_busy;
      bus.cfg_valid = ($urandom_range(0, 39) == 0);
      r = int'($urandom_range(0, 9));
      bus.cfg_div  = (r < 2) ? DIV_W'(r) : DIV_W'($urandom_range(2, 40));
      bus.cfg_frac = 4'($urandom_range(0, 15));
      cycle();
    end
    bus.cfg_valid = 1'b0;
    run(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
